// File: rtl/esp_pkg.sv
// Shared constants and types for the ESP receive path.
package esp_pkg;

    localparam logic [7:0] SOF = 8'hA5;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_LEN     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN_L,
        ST_LEN_H,
        ST_PAYLOAD,
        ST_CHK
    } state_t;

endpackage

// File: rtl/esp_rx_timeout.sv
// Inter-byte timeout: loadable, freezable down-counter with a terminal-count
// expire pulse. Load has priority over clear, clear over counting.
module esp_rx_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Reload on every received byte, park at zero while idle, count down while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_LOAD;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // A byte arriving in the terminal cycle wins, so load masks the expire.
    assign expire = run && !load && (cnt == CNT_ONE);

endmodule

// File: rtl/esp_rx_deframer.sv
// Drains the ESP UART RX FIFO, parses SOF/CMD/LEN/payload/CHK frames and
// presents the payload as a valid/ready byte stream with per-frame status.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | hunting for SOF, other bytes discarded
// ST_CMD     | next byte is CMD
// ST_LEN_L   | next byte is LEN low
// ST_LEN_H   | next byte is LEN high, length check and pkt_start
// ST_PAYLOAD | forwarding payload bytes, remaining counts down
// ST_CHK     | next byte is the checksum, pkt_done follows
module esp_rx_deframer
    import esp_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rxfifo_data,
    input  logic        rxfifo_not_empty,
    output logic        rxfifo_read,
    output logic        pkt_start,
    output logic [7:0]  pkt_cmd,
    output logic [15:0] pkt_len,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    input  logic        pay_ready,
    output logic        pkt_done,
    output logic [1:0]  pkt_err
);

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t      state;
    logic        rd_en;
    logic        rd_pending;
    logic [7:0]  acc;
    logic [7:0]  cmd_q;
    logic [7:0]  len_lo_q;
    logic [15:0] remaining;

    logic        byte_vld;
    logic        pay_stall;
    logic        to_expire;
    logic [15:0] len_rx;
    logic [7:0]  acc_next;

    assign byte_vld  = rd_pending;
    assign pay_stall = pay_valid && !pay_ready;
    assign len_rx    = {rxfifo_data, len_lo_q};
    assign acc_next  = acc + rxfifo_data;

    // rd_en keeps the pop strobe low while reset is held even if the FIFO has data.
    assign rxfifo_read = rd_en && rxfifo_not_empty && !rd_pending && !pay_stall;

    esp_rx_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (byte_vld),
        .clear  (state == ST_IDLE),
        .run    ((state != ST_IDLE) && !pay_stall),
        .expire (to_expire)
    );

    // Frame parser: one consumed byte per step, registered pulses and stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rd_en      <= 1'b0;
            rd_pending <= 1'b0;
            acc        <= 8'h00;
            cmd_q      <= 8'h00;
            len_lo_q   <= 8'h00;
            remaining  <= 16'h0000;
            pkt_start  <= 1'b0;
            pkt_cmd    <= 8'h00;
            pkt_len    <= 16'h0000;
            pay_data   <= 8'h00;
            pay_valid  <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_err    <= ERR_OK;
        end else begin
            rd_en      <= 1'b1;
            rd_pending <= rxfifo_read;
            pkt_start  <= 1'b0;
            pkt_done   <= 1'b0;
            if (pay_valid && pay_ready) begin
                pay_valid <= 1'b0;
            end

            if (to_expire) begin
                pkt_done  <= 1'b1;
                pkt_err   <= ERR_TIMEOUT;
                pay_valid <= 1'b0;
                state     <= ST_IDLE;
            end else if (byte_vld) begin
                case (state)
                    ST_IDLE: begin
                        if (rxfifo_data == SOF) begin
                            acc   <= 8'h00;
                            state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        cmd_q <= rxfifo_data;
                        acc   <= acc_next;
                        state <= ST_LEN_L;
                    end
                    ST_LEN_L: begin
                        len_lo_q <= rxfifo_data;
                        acc      <= acc_next;
                        state    <= ST_LEN_H;
                    end
                    ST_LEN_H: begin
                        acc <= acc_next;
                        if (len_rx > MAX_LEN_W) begin
                            pkt_done <= 1'b1;
                            pkt_err  <= ERR_LEN;
                            state    <= ST_IDLE;
                        end else begin
                            pkt_start <= 1'b1;
                            pkt_cmd   <= cmd_q;
                            pkt_len   <= len_rx;
                            remaining <= len_rx;
                            state     <= (len_rx != 16'h0000) ? ST_PAYLOAD : ST_CHK;
                        end
                    end
                    ST_PAYLOAD: begin
                        // The read that fetched this byte was only issued once the
                        // previous beat was gone, so the output slot is free here.
                        pay_data  <= rxfifo_data;
                        pay_valid <= 1'b1;
                        acc       <= acc_next;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        acc      <= acc_next;
                        pkt_done <= 1'b1;
                        pkt_err  <= (acc_next == 8'h00) ? ERR_OK : ERR_CHK;
                        state    <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_esp_rx_deframer.sv
// Directed bench for esp_rx_deframer: table of whole frames plus hand-written
// sequences for backpressure, starvation timeouts, maximum length and reset.
module tb_esp_rx_deframer;
    import esp_pkg::*;

    localparam int unsigned T_CYC = 40;
    localparam int unsigned MAXL  = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rxfifo_data = 8'h00;
    logic        rxfifo_not_empty;
    logic        rxfifo_read;
    logic        pkt_start;
    logic [7:0]  pkt_cmd;
    logic [15:0] pkt_len;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_ready = 1'b1;
    logic        pkt_done;
    logic [1:0]  pkt_err;

    int checks = 0;
    int errors = 0;

    esp_rx_deframer #(
        .MAX_LEN        (MAXL),
        .TIMEOUT_CYCLES (T_CYC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rxfifo_data      (rxfifo_data),
        .rxfifo_not_empty (rxfifo_not_empty),
        .rxfifo_read      (rxfifo_read),
        .pkt_start        (pkt_start),
        .pkt_cmd          (pkt_cmd),
        .pkt_len          (pkt_len),
        .pay_data         (pay_data),
        .pay_valid        (pay_valid),
        .pay_ready        (pay_ready),
        .pkt_done         (pkt_done),
        .pkt_err          (pkt_err)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after the pop strobe.
    logic [7:0] fifo_mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign rxfifo_not_empty = (wr_ptr != rd_ptr);

    always @(posedge clk) begin
        if (rxfifo_read && (wr_ptr != rd_ptr)) begin
            rxfifo_data <= fifo_mem[rd_ptr[11:0]];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[11:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Monitor, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_start = 0, n_done = 0, n_beat = 0, n_pv = 0, viol = 0;
    int start_cyc = 0, done_cyc = 0, first_pv_cyc = 0, last_beat_cyc = 0;
    bit want_first = 1'b0;
    logic [7:0]  last_cmd = 8'h00;
    logic [15:0] last_len = 16'h0000;
    logic [1:0]  last_err = 2'd0;
    logic [7:0]  beats [0:4095];

    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_start) begin
                n_start++;
                last_cmd   = pkt_cmd;
                last_len   = pkt_len;
                start_cyc  = cyc;
                want_first = 1'b1;
            end
            if (pay_valid) begin
                n_pv++;
                if (want_first) begin
                    first_pv_cyc = cyc;
                    want_first   = 1'b0;
                end
            end
            if (pay_valid && pay_ready) begin
                beats[n_beat[11:0]] = pay_data;
                n_beat++;
                last_beat_cyc = cyc;
            end
            if (pkt_done) begin
                n_done++;
                last_err = pkt_err;
                done_cyc = cyc;
            end
            if (pkt_start && pkt_done) begin
                viol++;
                $display("FAIL invariant start_and_done at cycle %0d", cyc);
            end
            if (rxfifo_read && !rxfifo_not_empty) begin
                viol++;
                $display("FAIL invariant read_when_empty at cycle %0d", cyc);
            end
            if (rxfifo_read && pay_valid && !pay_ready) begin
                viol++;
                $display("FAIL invariant read_during_stall at cycle %0d", cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int k = 0;
        while (n_done == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_done_seen"}, 32'(n_done != base), 32'd1);
    endtask

    // Frame bytes are right-aligned: byte k of nb is bytes[8*(nb-1-k) +: 8].
    typedef struct {
        logic [95:0] bytes;
        int          nb;
        bit          exp_start;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_len;
        int          npay;
        logic [31:0] pay;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs [0:8];

    task automatic apply_vec(input int i);
        vec_t v;
        int s0, b0, d0, p0;
        v  = vecs[i];
        s0 = n_start; b0 = n_beat; d0 = n_done; p0 = n_pv;
        for (int k = 0; k < v.nb; k++) push(v.bytes[8*(v.nb-1-k) +: 8]);
        wait_done(d0, 400, $sformatf("v%0d", i));
        repeat (4) @(negedge clk);
        chk($sformatf("v%0d_start_cnt", i), 32'(n_start - s0), 32'(v.exp_start));
        if (v.exp_start) begin
            chk($sformatf("v%0d_cmd", i), 32'(last_cmd), 32'(v.exp_cmd));
            chk($sformatf("v%0d_len", i), 32'(last_len), 32'(v.exp_len));
        end
        chk($sformatf("v%0d_beat_cnt", i), 32'(n_beat - b0), 32'(v.npay));
        for (int j = 0; j < v.npay; j++)
            chk($sformatf("v%0d_beat%0d", i, j), 32'(beats[(b0 + j) % 4096]),
                32'(v.pay[8*(v.npay-1-j) +: 8]));
        chk($sformatf("v%0d_done_cnt", i), 32'(n_done - d0), 32'd1);
        chk($sformatf("v%0d_err", i), 32'(last_err), 32'(v.exp_err));
        if (v.npay == 0) begin
            chk($sformatf("v%0d_no_pay_valid", i), 32'(n_pv - p0), 32'd0);
        end else begin
            chk($sformatf("v%0d_start_before_pv", i), 32'(first_pv_cyc > start_cyc), 32'd1);
            chk($sformatf("v%0d_done_after_beat", i), 32'(done_cyc > last_beat_cyc), 32'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, b0, d0, k, rd_cnt, bad;

        // 10+03+00+11+22+33 = 0x79, so CHK 0x87 closes the sum to zero.
        vecs[0] = '{96'hA510030011223387, 8, 1'b1, 8'h10, 16'd3, 3, 32'h112233, ERR_OK};
        vecs[1] = '{96'hA5420000BE, 5, 1'b1, 8'h42, 16'd0, 0, 32'h0, ERR_OK};
        vecs[2] = '{96'h00FF13A510030011223387, 11, 1'b1, 8'h10, 16'd3, 3, 32'h112233, ERR_OK};
        vecs[3] = '{96'hA510030011223398, 8, 1'b1, 8'h10, 16'd3, 3, 32'h112233, ERR_CHK};
        vecs[4] = '{96'hA510030011223397, 8, 1'b1, 8'h10, 16'd3, 3, 32'h112233, ERR_CHK};
        vecs[5] = '{96'hA5200104, 4, 1'b0, 8'h00, 16'd0, 0, 32'h0, ERR_LEN};
        // A5 as payload byte: 01+01+00+A5 = 0xA7, CHK 0x59.
        vecs[6] = '{96'hA5010100A559, 6, 1'b1, 8'h01, 16'd1, 1, 32'hA5, ERR_OK};
        // A5 as checksum byte: 5B+A5 = 0x100.
        vecs[7] = '{96'hA55B0000A5, 5, 1'b1, 8'h5B, 16'd0, 0, 32'h0, ERR_OK};
        vecs[8] = '{96'hA57EFFFF, 4, 1'b0, 8'h00, 16'd0, 0, 32'h0, ERR_LEN};

        // Reset state, with a byte waiting so the pop strobe is exercised.
        push(8'h00);
        repeat (3) @(negedge clk);
        chk("rst_rxfifo_read", 32'(rxfifo_read), 32'd0);
        chk("rst_pkt_start",   32'(pkt_start),   32'd0);
        chk("rst_pkt_done",    32'(pkt_done),    32'd0);
        chk("rst_pay_valid",   32'(pay_valid),   32'd0);
        chk("rst_pkt_len",     32'(pkt_len),     32'd0);
        chk("rst_pkt_err",     32'(pkt_err),     32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 9; i++) apply_vec(i);

        // Largest accepted length: 1024 bytes of 01 sum to 0 mod 256; 01+00+04 = 05, CHK FB.
        s0 = n_start; b0 = n_beat; d0 = n_done;
        push(8'hA5); push(8'h01); push(8'h00); push(8'h04);
        for (int j = 0; j < 1024; j++) push(8'h01);
        push(8'hFB);
        wait_done(d0, 4000, "maxlen");
        repeat (4) @(negedge clk);
        chk("maxlen_start_cnt", 32'(n_start - s0), 32'd1);
        chk("maxlen_len", 32'(last_len), 32'h400);
        chk("maxlen_beat_cnt", 32'(n_beat - b0), 32'd1024);
        bad = 0;
        for (int j = 0; j < 1024; j++) if (beats[(b0 + j) % 4096] !== 8'h01) bad++;
        chk("maxlen_beats_value", 32'(bad), 32'd0);
        chk("maxlen_err", 32'(last_err), 32'(ERR_OK));

        // Backpressure for 3x the timeout: no pops, no abort. 30+02+44+55 = CB, CHK 35.
        pay_ready = 1'b0;
        b0 = n_beat; d0 = n_done;
        push(8'hA5); push(8'h30); push(8'h02); push(8'h00); push(8'h44); push(8'h55); push(8'h35);
        k = 0;
        while (!pay_valid && k < 60) begin @(negedge clk); k++; end
        chk("stall_pv_seen", 32'(pay_valid), 32'd1);
        rd_cnt = 0;
        for (int j = 0; j < 3 * int'(T_CYC); j++) begin
            @(negedge clk);
            if (rxfifo_read) rd_cnt++;
        end
        chk("stall_no_reads", 32'(rd_cnt), 32'd0);
        chk("stall_no_done", 32'(n_done - d0), 32'd0);
        chk("stall_pv_held", 32'(pay_valid), 32'd1);
        chk("stall_data_held", 32'(pay_data), 32'h44);
        pay_ready = 1'b1;
        wait_done(d0, 100, "stall");
        repeat (4) @(negedge clk);
        chk("stall_beat_cnt", 32'(n_beat - b0), 32'd2);
        chk("stall_beat0", 32'(beats[b0 % 4096]), 32'h44);
        chk("stall_beat1", 32'(beats[(b0 + 1) % 4096]), 32'h55);
        chk("stall_err", 32'(last_err), 32'(ERR_OK));

        // FIFO starved after LEN_H.
        s0 = n_start; d0 = n_done;
        push(8'hA5); push(8'h31); push(8'h02); push(8'h00);
        wait_done(d0, 3 * int'(T_CYC), "starve");
        chk("starve_start_cnt", 32'(n_start - s0), 32'd1);
        chk("starve_err", 32'(last_err), 32'(ERR_TIMEOUT));
        chk("starve_delay", 32'((done_cyc - start_cyc >= int'(T_CYC) - 1) &&
                                (done_cyc - start_cyc <= int'(T_CYC) + 1)), 32'd1);
        @(negedge clk);
        chk("starve_pv_low", 32'(pay_valid), 32'd0);
        chk("starve_state_idle", 32'(dut.state), 32'(ST_IDLE));

        // Starved in CMD: abort without pkt_start.
        s0 = n_start; d0 = n_done;
        push(8'hA5);
        wait_done(d0, 3 * int'(T_CYC), "cmdto");
        repeat (2) @(negedge clk);
        chk("cmdto_start_cnt", 32'(n_start - s0), 32'd0);
        chk("cmdto_err", 32'(last_err), 32'(ERR_TIMEOUT));

        // Reset mid-payload. 50+04+01+02+03+04 = 5E, CHK A2 (drained as garbage).
        b0 = n_beat;
        push(8'hA5); push(8'h50); push(8'h04); push(8'h00);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'hA2);
        k = 0;
        while (n_beat == b0 && k < 60) begin @(negedge clk); k++; end
        chk("rstmid_beat_seen", 32'(n_beat != b0), 32'd1);
        d0 = n_done;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_rxfifo_read", 32'(rxfifo_read), 32'd0);
        chk("rstmid_pkt_start",   32'(pkt_start),   32'd0);
        chk("rstmid_pkt_cmd",     32'(pkt_cmd),     32'd0);
        chk("rstmid_pkt_len",     32'(pkt_len),     32'd0);
        chk("rstmid_pay_data",    32'(pay_data),    32'd0);
        chk("rstmid_pay_valid",   32'(pay_valid),   32'd0);
        chk("rstmid_pkt_done",    32'(pkt_done),    32'd0);
        chk("rstmid_pkt_err",     32'(pkt_err),     32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("rstmid_no_done", 32'(n_done - d0), 32'd0);
        chk("rstmid_state_idle", 32'(dut.state), 32'(ST_IDLE));
        apply_vec(1);
        apply_vec(0);

        chk("invariants", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
